// File: rtl/multiplicador_seq.sv
// Sequential shift-and-add multiplier: one partial product per clock, optional
// two's-complement handling via magnitude/sign split and a final re-sign step.
module multiplicador_seq #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           modo_sinal,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   z,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int unsigned CW = $clog2(N + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MUL   = 2'd1;
    localparam logic [1:0] ST_SINAL = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   ma_q, ma_d;
    logic [N-1:0]   mb_q, mb_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [2*N-1:0] p_q, p_d;

    logic           x_neg, z_neg;
    logic [2*N-1:0] ma_ext;

    assign x_neg  = modo_sinal & x[N-1];
    assign z_neg  = modo_sinal & z[N-1];
    assign ma_ext = {{N{1'b0}}, ma_q};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        p_d     = p_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // -2^(N-1) negates to itself, which is the correct unsigned magnitude
                    ma_d    = x_neg ? (-x) : x;
                    mb_d    = z_neg ? (-z) : z;
                    neg_d   = modo_sinal & (x[N-1] ^ z[N-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mb_q[0]) begin
                    acc_d = acc_q + (ma_ext << cnt_q);
                end
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_SINAL;
                end
            end
            ST_SINAL: begin
                p_d     = neg_q ? (-acc_q) : acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            p_q     <= p_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Scoreboard bench for multiplicador_seq: the driver queues hand-computed products,
// a monitor pops and compares them on every done pulse.
module tb_multiplicador_seq;

    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           modo_sinal;
    logic [N-1:0]   x;
    logic [N-1:0]   z;
    logic           busy;
    logic           done;
    logic [2*N-1:0] p;

    logic [2*N-1:0] exp_q[$];
    logic [2*N-1:0] last_p;
    int             n_vec;
    int             n_fail;

    multiplicador_seq #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .modo_sinal (modo_sinal),
        .x          (x),
        .z          (z),
        .busy       (busy),
        .done       (done),
        .p          (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*N-1:0] act,
                         input logic [2*N-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: result compare on done, p stability between completions
    initial last_p = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            last_p = '0;
        end else if (done === 1'b1) begin
            check("busy_during_done", {7'd0, busy}, 8'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_done: got p=%h, expected no done at %0t", p, $time);
            end else begin
                check("product", p, exp_q.pop_front());
            end
            last_p = p;
        end else begin
            check("p_stable", p, last_p);
        end
    end

    // One operation with latency checks; inputs are scrambled while busy
    task automatic run_op(input logic m, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] e);
        @(negedge clk);
        modo_sinal = m;
        x          = a;
        z          = b;
        start      = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start      = 1'b0;
        modo_sinal = ~m;
        x          = ~a;
        z          = b + 4'd3;
        check("busy_after_start", {7'd0, busy}, 8'd1);
        for (int k = 1; k <= N + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
            if (k == N) check("done_early", {7'd0, done}, 8'd0);
            if (k == N + 1) begin
                check("done_latency", {7'd0, done}, 8'd1);
                check("busy_cleared", {7'd0, busy}, 8'd0);
            end
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", {7'd0, done}, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        modo_sinal = 1'b0;
        x          = '0;
        z          = '0;
        #12;
        check("reset_busy", {7'd0, busy}, 8'd0);
        check("reset_done", {7'd0, done}, 8'd0);
        check("reset_p", p, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-run: no result expected
        @(negedge clk);
        modo_sinal = 1'b1;
        x          = 4'd7;
        z          = 4'd3;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_busy", {7'd0, busy}, 8'd0);
        check("midrun_done", {7'd0, done}, 8'd0);
        check("midrun_p", p, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);

        run_op(1'b1, 4'd2, 4'd3, 8'h06);
        run_op(1'b1, 4'b1000, 4'b1000, 8'h40);
        run_op(1'b1, 4'b1000, 4'd7, 8'hC8);
        run_op(1'b1, 4'hF, 4'hF, 8'h01);
        run_op(1'b0, 4'hF, 4'hF, 8'hE1);
        run_op(1'b1, 4'hF, 4'hF, 8'h01);
        run_op(1'b1, 4'd0, 4'hB, 8'h00);
        run_op(1'b1, 4'hD, 4'd5, 8'hF1);
        run_op(1'b0, 4'b1000, 4'b1000, 8'h40);
        run_op(1'b1, 4'd7, 4'd7, 8'h31);
        run_op(1'b1, 4'd7, 4'b1000, 8'hC8);
        run_op(1'b0, 4'hA, 4'd3, 8'h1E);
        run_op(1'b1, 4'd0, 4'b1000, 8'h00);

        // Back-to-back: start held high, done every N+2 cycles
        @(negedge clk);
        modo_sinal = 1'b0;
        x          = 4'd3;
        z          = 4'd2;
        start      = 1'b1;
        repeat (3) exp_q.push_back(8'h06);
        @(posedge clk);
        for (int k = 1; k <= 3 * (N + 2) - 1; k++) begin
            @(posedge clk);
            #1;
            if (k == 16) start = 1'b0;
            check("b2b_done", {7'd0, done},
                  {7'd0, (k == N + 1) || (k == 2 * N + 3) || (k == 3 * N + 5)});
        end
        repeat (4) @(posedge clk);
        check("queue_drained", exp_q.size(), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplicador_seq.md
Name: multiplicador_seq

Overview:
- Sequential shift-and-add multiplier for the ALU datapath.
- Sits directly downstream of the 4-bit operand complementer. It consumes two N-bit operands (x, z).
- In signed mode, it takes magnitudes by two's complement, runs one add/shift per clock, and re-applies the sign to the 2N-bit product.
- A start/busy/done handshake lets the ALU control sequence it alongside the combinational operations.

Parameters:
- N, 4, operand width; product is 2N bits; iteration count = N.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiplication; sampled only in IDLE.
- modo_sinal  input  1  1 = operands and product are two's-complement signed; 0 = unsigned. Sampled with start.
- x  input  N  multiplicand, sampled with start.
- z  input  N  multiplier, sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when p is updated.
- p  output  2N  product; holds its value until the next completion.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (rst_n low, any time, including mid-operation):
  - state = IDLE; busy = 0; done = 0; p = 0.
  - Internal accumulator, counter and operand registers are cleared.
  - The in-flight operation is discarded with no done pulse.
  - Deassertion takes effect at the next clk edge.
- State machine: IDLE, MUL, SINAL.
- IDLE:
  - done = 0 except on the cycle immediately after SINAL.
  - On an edge with start = 1, the block latches:
    - ma = |x| and mb = |z| as N-bit unsigned magnitudes, using the two's complement when modo_sinal = 1 and the operand MSB = 1; raw operands when modo_sinal = 0.
    - neg = modo_sinal & (x[N-1] ^ z[N-1]).
  - At that edge: acc = 0, cnt = 0, busy = 1, go to MUL.
- MUL (N edges):
  - Each edge: if mb[0], acc = acc + (ma << cnt) in 2N-bit arithmetic with no overflow possible.
  - Then mb = mb >> 1 and cnt = cnt + 1.
  - After the edge where cnt reaches N-1 → SINAL.
- SINAL (1 edge):
  - p = neg ? (~acc + 1) : acc, truncated to 2N bits.
  - done = 1 for exactly one cycle; busy = 0; go to IDLE.
- Latency:
  - Start is sampled at edge E0. p and done update at edge E0+N+1 (E0+5 for N=4).
  - busy is high from E0 through E0+N+1 (exclusive).
  - Back-to-back: start may be high in the same cycle that done is high. It is accepted at that edge and busy returns high.
- start while busy: ignored, no effect on the operation; x, z and modo_sinal may change freely after E0.
- Range rules:
  - Magnitude of -2^(N-1) (e.g. -8) is 2^(N-1), represented correctly as unsigned N bits.
  - Signed range is -2^(2N-2)+2^(N-1) .. 2^(2N-2), e.g. -56..64 for N=4.
  - Unsigned max is (2^N-1)^2, e.g. 225.
  - Any operand zero → p = 0; negative zero is never produced.
- done and p change only at SINAL edges (or reset). p is never glitched mid-operation.

Test Plan:
- Reset mid-run: start x=7, z=3 signed; drop rst_n 2 cycles later → busy = 0, done never pulses, p = 0. After release, start x=2, z=3 → p = 6 at E0+5.
- Signed corners, one at a time: x=4'b1000 (-8), z=4'b1000 (-8) → p = 8'h40 (64). x=-8, z=7 → p = 8'hC8 (-56). x=-1, z=-1 → p = 8'h01.
- Unsigned max: modo_sinal=0, x=15, z=15 → p = 8'hE1 (225). Same bits with modo_sinal=1 → p = 8'h01.
- Zero and sign: x=0, z=-5 signed → p = 8'h00. x=-3, z=5 → p = 8'hF1 (-15).
- Handshake: hold start high continuously with x=3, z=2 → done pulses every 6 cycles with p = 6. Change x/z while busy → result unaffected. busy is never high during a done cycle.
- Latency check: start at E0 → done high exactly in the cycle after edge E0+5 and for one cycle only. p remains stable until the next done.
